main_mem_responder: RTL and testbench

Memory-side responder for the core's main-memory request interface. It accepts `main_mem_read_request` / `main_mem_write_request` and `lock_en` / `unlock_en` pulses from up to NCORE decoding cores, and arbitrates round-robin. It drives one synchronous single-port main memory and returns read data plus a per-core acknowledge, which the pipeline uses as its memory-stall release. It also owns the global lock that serialises LOCK/UNLOCK critical sections across cores.

---
 rtl/main_mem_pkg.sv | 25 ++
 rtl/main_mem_responder_rr_arbiter.sv | 35 +++
 rtl/main_mem_responder.sv | 142 ++++++++++++++
 tb/tb_main_mem_responder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/main_mem_pkg.sv
// Shared types, default sizes and the rotate-priority helper for the main-memory responder.
package main_mem_pkg;

  localparam int NCORE_DEF  = 2;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [1:0] ST_IDLE   = 2'(IDLE);
  localparam logic [1:0] ST_ACCESS = 2'(ACCESS);
  localparam logic [1:0] ST_RESP   = 2'(RESP);

  // Index visited at step 'off' of a priority search that starts at 'base'.
  function automatic int unsigned rot_idx(input int unsigned base,
                                          input int unsigned off,
                                          input int unsigned n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/main_mem_responder_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after rr_ptr, wrapping.
module rr_arbiter
  import main_mem_pkg::*;
#(
  parameter int NCORE = 2,
  parameter int IDX_W = 1
) (
  input  logic [NCORE-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [NCORE-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             valid
);

  int unsigned          k;
  logic [IDX_W-1:0]     kk;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    k         = 0;
    kk        = '0;
    for (int i = 0; i < NCORE; i++) begin
      k  = rot_idx(32'(rr_ptr), unsigned'(i), unsigned'(NCORE));
      kk = IDX_W'(k);
      if (!valid && req[kk]) begin
        valid     = 1'b1;
        grant[kk] = 1'b1;
        grant_idx = kk;
      end
    end
  end

endmodule

// File: rtl/main_mem_responder.sv
// Round-robin responder between NCORE cores and one synchronous single-port memory,
// plus the global LOCK/UNLOCK owner. Lock ownership is built only when MAIN_MEM_LOCK_EN is defined.
module main_mem_responder
  import main_mem_pkg::*;
#(
  parameter int NCORE  = NCORE_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NCORE-1:0]        rd_req,
  input  logic [NCORE-1:0]        wr_req,
  input  logic [NCORE*ADDR_W-1:0] req_adr,
  input  logic [NCORE*DATA_W-1:0] req_wdata,
  input  logic [NCORE-1:0]        lock_req,
  input  logic [NCORE-1:0]        unlock_req,
  output logic [NCORE-1:0]        ack,
  output logic [DATA_W-1:0]       rdata,
  output logic [NCORE-1:0]        lock_ack,
  output logic [ADDR_W-1:0]       mem_adr,
  output logic [DATA_W-1:0]       mem_wdata,
  output logic                    mem_we,
  input  logic [DATA_W-1:0]       mem_rdata
);

  localparam int IDX_W = (NCORE > 1) ? $clog2(NCORE) : 1;

  logic [1:0]        state;
  logic [IDX_W-1:0]  g_idx;
  logic [IDX_W-1:0]  rr_ptr;
  logic [NCORE-1:0]  cand;
  logic [NCORE-1:0]  acc_grant;
  logic [IDX_W-1:0]  acc_idx;
  logic              acc_valid;
  logic [ADDR_W-1:0] sel_adr;
  logic [DATA_W-1:0] sel_wdata;
  logic [NCORE-1:0]  g_onehot;

  rr_arbiter #(.NCORE(NCORE), .IDX_W(IDX_W)) u_acc_arb (
    .req       (cand),
    .rr_ptr    (rr_ptr),
    .grant     (acc_grant),
    .grant_idx (acc_idx),
    .valid     (acc_valid)
  );

  always_comb begin
    sel_adr   = req_adr[acc_idx*ADDR_W +: ADDR_W];
    sel_wdata = req_wdata[acc_idx*DATA_W +: DATA_W];
  end

  // Read wins when a core raises both; the write is dropped and the access acks as a read.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      g_idx     <= '0;
      rr_ptr    <= '0;
      mem_adr   <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (acc_valid) begin
            state     <= ST_ACCESS;
            g_idx     <= acc_idx;
            rr_ptr    <= (acc_idx == IDX_W'(NCORE - 1)) ? '0 : acc_idx + 1'b1;
            mem_adr   <= sel_adr;
            mem_wdata <= sel_wdata;
            mem_we    <= |(acc_grant & wr_req & ~rd_req);
          end
        end
        ST_ACCESS: begin
          mem_we <= 1'b0;
          state  <= ST_RESP;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    g_onehot        = '0;
    g_onehot[g_idx] = 1'b1;
    ack             = (state == ST_RESP) ? g_onehot : '0;
    rdata           = (state == ST_RESP) ? mem_rdata : '0;
  end

`ifdef MAIN_MEM_LOCK_EN
  logic             held;
  logic [IDX_W-1:0] owner;
  logic [NCORE-1:0] owner_mask;
  logic [NCORE-1:0] lk_grant;
  logic [IDX_W-1:0] lk_idx;
  logic             lk_valid;

  rr_arbiter #(.NCORE(NCORE), .IDX_W(IDX_W)) u_lock_arb (
    .req       (lock_req),
    .rr_ptr    (rr_ptr),
    .grant     (lk_grant),
    .grant_idx (lk_idx),
    .valid     (lk_valid)
  );

  always_comb begin
    owner_mask        = '0;
    owner_mask[owner] = 1'b1;
    cand              = (rd_req | wr_req) & (held ? owner_mask : '1);
  end

  // Release takes priority: a pending lock is only granted once held has dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      held     <= 1'b0;
      owner    <= '0;
      lock_ack <= '0;
    end else begin
      lock_ack <= '0;
      if (held) begin
        if (unlock_req[owner]) held <= 1'b0;
      end else if (lk_valid) begin
        held     <= 1'b1;
        owner    <= lk_idx;
        lock_ack <= lk_grant;
      end
    end
  end
`else
  logic unused_unlock;

  assign unused_unlock = ^unlock_req;

  always_comb cand = rd_req | wr_req;

  always_ff @(posedge clk) begin
    if (reset) lock_ack <= '0;
    else       lock_ack <= lock_req;
  end
`endif

endmodule

// File: tb/tb_main_mem_responder.sv
// Directed scoreboard bench for main_mem_responder with a behavioural synchronous memory.
module tb_main_mem_responder;

  logic        clk;
  logic        reset;
  logic [1:0]  rd_req;
  logic [1:0]  wr_req;
  logic [31:0] req_adr;
  logic [31:0] req_wdata;
  logic [1:0]  lock_req;
  logic [1:0]  unlock_req;
  logic [1:0]  ack;
  logic [15:0] rdata;
  logic [1:0]  lock_ack;
  logic [15:0] mem_adr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] mem_rdata;

  logic [15:0] mem [0:255];
  logic [19:0] exp_q[$];
  logic [19:0] sb_e;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;

  main_mem_responder dut (
    .clk        (clk),
    .reset      (reset),
    .rd_req     (rd_req),
    .wr_req     (wr_req),
    .req_adr    (req_adr),
    .req_wdata  (req_wdata),
    .lock_req   (lock_req),
    .unlock_req (unlock_req),
    .ack        (ack),
    .rdata      (rdata),
    .lock_ack   (lock_ack),
    .mem_adr    (mem_adr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  // clock / reset / memory
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h12] = 16'hBEEF;
  end

  always @(posedge clk) begin
    if (mem_we) mem[mem_adr[7:0]] <= mem_wdata;
    mem_rdata <= mem[mem_adr[7:0]];
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (|ack) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected actual ack %b required none", ack);
      end else begin
        sb_e = exp_q.pop_front();
        chk("sb_core", 32'(ack), 32'(1) << sb_e[19:17]);
        if (sb_e[16]) chk("sb_rdata", 32'(rdata), 32'(sb_e[15:0]));
      end
    end
  end

  // driver tasks
  task automatic do_reset();
    reset = 1'b1;
    rd_req = '0; wr_req = '0; lock_req = '0; unlock_req = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic access_fixed(input int core, input logic wr, input logic rd,
                              input logic [15:0] adr, input logic [15:0] wdata,
                              input logic [15:0] exp_data);
    exp_q.push_back({3'(core), rd, exp_data});
    @(negedge clk);
    req_adr[core*16 +: 16]   = adr;
    req_wdata[core*16 +: 16] = wdata;
    rd_req[core] = rd;
    wr_req[core] = wr;
    @(negedge clk);
    chk("adr_t1", 32'(mem_adr), 32'(adr));
    chk("we_t1", 32'(mem_we), 32'(wr & ~rd));
    if (wr & ~rd) chk("wdata_t1", 32'(mem_wdata), 32'(wdata));
    chk("ack_early", 32'(ack), 0);
    @(negedge clk);
    chk("we_t2", 32'(mem_we), 0);
    chk("ack_t2", 32'(ack), 32'(1) << core);
    rd_req[core] = 1'b0;
    wr_req[core] = 1'b0;
  endtask

  initial begin
    int last;
    logic hit;
    req_adr = '0; req_wdata = '0;
    do_reset();

    // reset state
    chk("rst_ack", 32'(ack), 0);
    chk("rst_lock_ack", 32'(lock_ack), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_adr", 32'(mem_adr), 0);
    chk("rst_wdata", 32'(mem_wdata), 0);
    chk("rst_rdata", 32'(rdata), 0);

    access_fixed(0, 1'b0, 1'b1, 16'h0012, 16'h0000, 16'hBEEF);
    access_fixed(1, 1'b1, 1'b0, 16'h0040, 16'h1234, 16'h0000);
    access_fixed(0, 1'b0, 1'b1, 16'h0040, 16'h0000, 16'h1234);
    // both raised: read wins, write to 0x12 dropped
    access_fixed(0, 1'b1, 1'b1, 16'h0012, 16'h5555, 16'hBEEF);

    // contention: alternating grants 3 cycles apart
    do_reset();
    for (int k = 0; k < 6; k++)
      exp_q.push_back({3'(k % 2), 1'b1, (k % 2 == 1) ? 16'h1234 : 16'hBEEF});
    @(negedge clk);
    req_adr = {16'h0040, 16'h0012};
    rd_req = 2'b11;
    last = 0;
    for (int k = 0; k < 6; k++) begin
      hit = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (|ack) begin hit = 1'b1; break; end
      end
      chk("contend_hit", 32'(hit), 1);
      chk("contend_core", 32'(ack), (k % 2 == 1) ? 2 : 1);
      if (k > 0) chk("contend_gap", cyc - last, 3);
      last = cyc;
      if (!hit) break;
    end
    rd_req = 2'b00;

    do_reset();
`ifdef MAIN_MEM_LOCK_EN
    @(negedge clk);
    lock_req[0] = 1'b1;
    @(negedge clk);
    chk("lock_ack0", 32'(lock_ack), 1);
    lock_req[0] = 1'b0;
    lock_req[1] = 1'b1;
    req_adr[31:16] = 16'h0040;
    rd_req[1] = 1'b1;
    for (int n = 0; n < 3; n++)
      access_fixed(0, 1'b0, 1'b1, 16'h0012, 16'h0000, 16'hBEEF);
    chk("lock1_blocked", 32'(lock_ack), 0);
    @(negedge clk);
    unlock_req[1] = 1'b1;
    @(negedge clk);
    unlock_req[1] = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("nonowner_blocked", 32'({ack, lock_ack}), 0);
    end
    exp_q.push_back({3'd1, 1'b1, 16'h1234});
    @(negedge clk);
    unlock_req[0] = 1'b1;
    @(negedge clk);
    unlock_req[0] = 1'b0;
    chk("unlock_lat1", 32'(lock_ack), 0);
    @(negedge clk);
    chk("lock_ack1", 32'(lock_ack), 2);
    lock_req[1] = 1'b0;
    @(negedge clk);
    chk("core1_ack", 32'(ack), 2);
    rd_req[1] = 1'b0;
    @(negedge clk);
    unlock_req[1] = 1'b1;
    @(negedge clk);
    unlock_req[1] = 1'b0;
`else
    @(negedge clk);
    lock_req = 2'b11;
    unlock_req[0] = 1'b1;
    @(negedge clk);
    chk("lock_ack_both", 32'(lock_ack), 3);
    lock_req = 2'b00;
    unlock_req = 2'b00;
    @(negedge clk);
    chk("lock_ack_drop", 32'(lock_ack), 0);
    lock_req[0] = 1'b1;
    access_fixed(1, 1'b0, 1'b1, 16'h0040, 16'h0000, 16'h1234);
    lock_req[0] = 1'b0;
`endif

    // reset while in ACCESS aborts the read
    @(negedge clk);
    req_adr[15:0] = 16'h0012;
    rd_req[0] = 1'b1;
    @(negedge clk);
    chk("abort_adr_t1", 32'(mem_adr), 32'h12);
    reset = 1'b1;
    rd_req[0] = 1'b0;
    @(negedge clk);
    chk("abort_ack", 32'(ack), 0);
    chk("abort_rdata", 32'(rdata), 0);
    chk("abort_we", 32'(mem_we), 0);
    chk("abort_adr", 32'(mem_adr), 0);
    chk("abort_wdata", 32'(mem_wdata), 0);
    chk("abort_lock_ack", 32'(lock_ack), 0);
    reset = 1'b0;
    access_fixed(0, 1'b0, 1'b1, 16'h0040, 16'h0000, 16'h1234);

    repeat (4) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
